reg_bank: RTL and testbench

- Architectural register bank of the 8-bit core, directly downstream of the write-back stage.
- Consumes the write-back stage outputs (write enable, destination index, selected data) and provides two combinational read ports to decode.
- A per-register pending-write scoreboard lets decode detect RAW hazards and stall.

---
 rtl/reg_bank_if.sv | 30 +++
 rtl/reg_bank.sv | 98 +++++++++
 tb/tb_reg_bank.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/reg_bank_if.sv
// rtl/reg_bank_if.sv - write-back, decode read-port and scoreboard signals of the register bank
interface reg_bank_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic                     WR;
  logic [ADDR_W-1:0]        rd;
  logic [DATA_W-1:0]        data;
  logic [ADDR_W-1:0]        rs1;
  logic [ADDR_W-1:0]        rs2;
  logic                     use1;
  logic                     use2;
  logic                     issue;
  logic [ADDR_W-1:0]        issueRd;
  logic [DATA_W-1:0]        rdata1;
  logic [DATA_W-1:0]        rdata2;
  logic                     stall;
  logic [(1<<ADDR_W)-1:0]   busy;
  logic                     err;

  modport master (
    output WR, rd, data, rs1, rs2, use1, use2, issue, issueRd,
    input  rdata1, rdata2, stall, busy, err
  );

  modport slave (
    input  WR, rd, data, rs1, rs2, use1, use2, issue, issueRd,
    output rdata1, rdata2, stall, busy, err
  );
endinterface

// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - register bank with per-register pending-write scoreboard
// Optional write-through forwarding and same-cycle hazard release under RB_BYPASS_EN.
module reg_bank #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int CNT_W  = 2
) (
  input  logic      clk,
  input  logic      rst,
  reg_bank_if.slave bus
);
  localparam int NREGS = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [CNT_W-1:0]  cnt_q  [NREGS];
  logic [CNT_W-1:0]  cnt_d  [NREGS];
  logic              err_q;
  logic              err_d;

  logic              haz1;
  logic              haz2;
  logic              sat;
  logic              stall;
  logic              issue_acc;
  logic [NREGS-1:0]  inc_v;
  logic [NREGS-1:0]  dec_v;

  always_comb begin
    bus.rdata1 = regs_q[bus.rs1];
    bus.rdata2 = regs_q[bus.rs2];
`ifdef RB_BYPASS_EN
    if (bus.WR && (bus.rd == bus.rs1)) bus.rdata1 = bus.data;
    if (bus.WR && (bus.rd == bus.rs2)) bus.rdata2 = bus.data;
`endif
  end

  always_comb begin
    haz1 = bus.use1 && (cnt_q[bus.rs1] != '0);
    haz2 = bus.use2 && (cnt_q[bus.rs2] != '0);
`ifdef RB_BYPASS_EN
    // The last outstanding write lands this cycle, so the forwarded value is already correct.
    if (bus.WR && (bus.rd == bus.rs1) && (cnt_q[bus.rs1] == CNT_ONE)) haz1 = 1'b0;
    if (bus.WR && (bus.rd == bus.rs2) && (cnt_q[bus.rs2] == CNT_ONE)) haz2 = 1'b0;
`endif
    sat       = bus.issue && (cnt_q[bus.issueRd] == CNT_MAX);
    stall     = haz1 || haz2 || sat;
    issue_acc = bus.issue && !stall;
  end

  assign bus.stall = stall;
  assign bus.err   = err_q;

  always_comb begin
    inc_v    = '0;
    dec_v    = '0;
    bus.busy = '0;
    for (int i = 0; i < NREGS; i++) begin
      inc_v[i]    = issue_acc && (bus.issueRd == ADDR_W'(i));
      dec_v[i]    = bus.WR && (bus.rd == ADDR_W'(i)) && (cnt_q[i] != '0);
      bus.busy[i] = |cnt_q[i];
    end
  end

  always_comb begin
    regs_d = regs_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (bus.WR) begin
      regs_d[bus.rd] = bus.data;
      if (cnt_q[bus.rd] == '0) err_d = 1'b1;
    end
    // An issue and a retire on the same register cancel out.
    for (int i = 0; i < NREGS; i++) begin
      if (inc_v[i] && !dec_v[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (dec_v[i] && !inc_v[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end
endmodule

// File: tb/tb_reg_bank.sv
// tb/tb_reg_bank.sv - directed and randomized checks of reg_bank against a behavioural model
module tb_reg_bank;
  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  reg_bank_if #(.DATA_W(8), .ADDR_W(2)) bus ();

  reg_bank #(.DATA_W(8), .ADDR_W(2), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [7:0] m_reg [4];
  int         m_cnt [4];
  bit         m_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_rdata(input logic [1:0] rs);
`ifdef RB_BYPASS_EN
    if (bus.WR && bus.rd == rs) return bus.data;
`endif
    return m_reg[rs];
  endfunction

  function automatic bit src_hazard(input bit use_it, input logic [1:0] rs);
    if (!use_it || m_cnt[rs] == 0) return 1'b0;
`ifdef RB_BYPASS_EN
    if (bus.WR && bus.rd == rs && m_cnt[rs] == 1) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic bit exp_stall();
    return src_hazard(bus.use1, bus.rs1) || src_hazard(bus.use2, bus.rs2) ||
           (bus.issue && m_cnt[bus.issueRd] == 3);
  endfunction

  function automatic logic [3:0] exp_busy();
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = (m_cnt[i] != 0);
    return b;
  endfunction

  task automatic idle();
    rst = 1'b0;
    bus.WR = 1'b0; bus.rd = 2'd0; bus.data = 8'h00;
    bus.rs1 = 2'd0; bus.rs2 = 2'd0; bus.use1 = 1'b0; bus.use2 = 1'b0;
    bus.issue = 1'b0; bus.issueRd = 2'd0;
  endtask

  // Compare every output with the model, then advance one clock and update the model.
  task automatic tick();
    bit st;
    int d [4];
    #1;
    st = exp_stall();
    chk("rdata1", bus.rdata1, exp_rdata(bus.rs1));
    chk("rdata2", bus.rdata2, exp_rdata(bus.rs2));
    chk("stall",  bus.stall,  st);
    chk("busy",   bus.busy,   exp_busy());
    chk("err",    bus.err,    m_err);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 4; i++) begin m_reg[i] = 8'h00; m_cnt[i] = 0; end
      m_err = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) d[i] = 0;
      if (bus.issue && !st) d[bus.issueRd] += 1;
      if (bus.WR) begin
        if (m_cnt[bus.rd] == 0) m_err = 1'b1;
        else d[bus.rd] -= 1;
        m_reg[bus.rd] = bus.data;
      end
      for (int i = 0; i < 4; i++) m_cnt[i] += d[i];
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; tick(); idle();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin m_reg[i] = 8'hxx; m_cnt[i] = 0; end
    m_err = 1'b0;
    idle();
    rst = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    @(negedge clk);
    idle();

    // Reset clears data, scoreboard and err
    bus.WR = 1'b1; bus.rd = 2'd2; bus.data = 8'h5A; tick(); idle();
    bus.rs1 = 2'd2; #1 chk("pre_rst_r2", bus.rdata1, 8'h5A); tick();
    do_reset();
    for (int r = 0; r < 4; r++) begin
      bus.rs1 = 2'(r); bus.rs2 = 2'(3 - r);
      #1 chk("rst_rdata", bus.rdata1, 8'h00);
      chk("rst_busy", bus.busy, 4'b0000);
      chk("rst_err", bus.err, 1'b0);
      chk("rst_stall", bus.stall, 1'b0);
      tick();
    end

    // Basic write/read, both ports on the same register
    idle(); bus.WR = 1'b1; bus.rd = 2'd1; bus.data = 8'hA5; tick(); idle();
    bus.rs1 = 2'd1; bus.rs2 = 2'd1;
    #1 chk("wr_rd1", bus.rdata1, 8'hA5); chk("wr_rd2", bus.rdata2, 8'hA5);
    tick();

    // RAW stall on r3 until its write-back
    do_reset();
    bus.issue = 1'b1; bus.issueRd = 2'd3; tick(); idle();
    bus.use1 = 1'b1; bus.rs1 = 2'd3;
    #1 chk("raw_stall", bus.stall, 1'b1); chk("raw_busy", bus.busy, 4'b1000);
    tick(); tick();
    bus.WR = 1'b1; bus.rd = 2'd3; bus.data = 8'h3C;
`ifdef RB_BYPASS_EN
    #1 chk("raw_wb_stall", bus.stall, 1'b0); chk("raw_wb_fwd", bus.rdata1, 8'h3C);
`else
    #1 chk("raw_wb_stall", bus.stall, 1'b1);
`endif
    tick();
    bus.WR = 1'b0;
    #1 chk("raw_release", bus.stall, 1'b0); chk("raw_data", bus.rdata1, 8'h3C);
    tick();

    // Simultaneous issue and retire
    do_reset();
    bus.issue = 1'b1; bus.issueRd = 2'd2; tick();
    bus.WR = 1'b1; bus.rd = 2'd2; bus.data = 8'h22; tick(); idle();
    #1 chk("sim_same", bus.busy, 4'b0100);
    bus.WR = 1'b1; bus.rd = 2'd2; bus.issue = 1'b1; bus.issueRd = 2'd1; tick(); idle();
    #1 chk("sim_swap", bus.busy, 4'b0010);
    bus.WR = 1'b1; bus.rd = 2'd1; bus.issue = 1'b1; bus.issueRd = 2'd0; tick(); idle();
    #1 chk("sim_diff", bus.busy, 4'b0001); chk("sim_err", bus.err, 1'b0);
    bus.WR = 1'b1; bus.rd = 2'd0; tick(); idle();

    // Saturation at three in-flight writes
    bus.issue = 1'b1; bus.issueRd = 2'd1;
    for (int k = 0; k < 3; k++) tick();
    #1 chk("sat_stall", bus.stall, 1'b1);
    tick(); idle();
    bus.WR = 1'b1; bus.rd = 2'd1; bus.data = 8'h77; tick(); idle();
    bus.issue = 1'b1; bus.issueRd = 2'd1;
    #1 chk("sat_release", bus.stall, 1'b0);
    tick(); idle();
    bus.WR = 1'b1; bus.rd = 2'd1;
    for (int k = 0; k < 3; k++) tick();
    idle(); #1 chk("sat_drain", bus.busy, 4'b0000); chk("sat_err", bus.err, 1'b0);
    tick();

    // Underflow sets a sticky err
    bus.WR = 1'b1; bus.rd = 2'd0; bus.data = 8'h11; tick(); idle();
    #1 chk("uf_err", bus.err, 1'b1); chk("uf_data", bus.rdata1, 8'h11);
    bus.issue = 1'b1; bus.issueRd = 2'd2; tick();
    bus.issue = 1'b0; bus.WR = 1'b1; bus.rd = 2'd2; tick(); idle();
    #1 chk("uf_sticky", bus.err, 1'b1);
    do_reset();
    #1 chk("uf_clear", bus.err, 1'b0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      rst         = ($urandom_range(0, 59) == 0);
      bus.WR      = ($urandom_range(0, 2) == 0);
      bus.rd      = 2'($urandom_range(0, 3));
      bus.data    = 8'($urandom);
      bus.rs1     = 2'($urandom_range(0, 3));
      bus.rs2     = 2'($urandom_range(0, 3));
      bus.use1    = 1'($urandom);
      bus.use2    = 1'($urandom);
      bus.issue   = ($urandom_range(0, 1) == 0);
      bus.issueRd = 2'($urandom_range(0, 3));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
